regfile_2r1w: RTL and testbench

- Parametrised register file: DEPTH entries of DATA_W bits, one write port and two read ports.
- Reads are registered (1-cycle latency) with write-first bypass.
- Entry 0 is an optional hardwired constant.
- Feeds the SIPO/PISO datapath as operand storage for the serial converters and their control logic.

---
 rtl/regfile_2r1w.sv | 100 ++++++++++
 tb/tb_regfile_2r1w.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file, registered reads with write-first bypass.
// Optional PARITY_EN macro adds per-entry even parity and the rd_perr flag.
module regfile_2r1w #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int R0_CONST     = 13,
  parameter int R0_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid
`ifdef PARITY_EN
  ,
  output logic              rd_perr
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] R0_VAL = DATA_W'(R0_CONST);
  localparam bit HW = (R0_HARDWIRED != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              z1, z2;
  logic              byp1, byp2;
  logic              wr_ok;
  logic [DATA_W-1:0] nxt1, nxt2;

  // Hardwired entry 0 never takes writes and never bypasses.
  always_comb begin
    z1    = HW && (rd_addr1 == '0);
    z2    = HW && (rd_addr2 == '0);
    wr_ok = wr_en && !(HW && (wr_addr == '0));
    byp1  = wr_en && (wr_addr == rd_addr1) && !z1;
    byp2  = wr_en && (wr_addr == rd_addr2) && !z2;
    nxt1  = byp1 ? wr_data : mem[rd_addr1];
    nxt2  = byp2 ? wr_data : mem[rd_addr2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == 0) ? R0_VAL : '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data1 <= nxt1;
        rd_data2 <= nxt2;
      end
    end
  end

`ifdef PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             np1, np2;
  logic             err1, err2;

  always_comb begin
    np1  = byp1 ? ^wr_data : par_q[rd_addr1];
    np2  = byp2 ? ^wr_data : par_q[rd_addr2];
    err1 = ((^nxt1) ^ np1) && !z1;
    err2 = ((^nxt2) ^ np2) && !z2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        par_q[i] <= (i == 0) ? ^R0_VAL : 1'b0;
    end else if (wr_ok) begin
      par_q[wr_addr] <= ^wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_perr <= 1'b0;
    else
      rd_perr <= rd_en && (err1 || err2);
  end
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: hardwired and writable entry-0 builds
// driven in lockstep; expected reads queued at drive time, popped after edge.
module tb_regfile_2r1w;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_addr1 = '0;
  logic [2:0] rd_addr2 = '0;

  logic [7:0] h_d1, h_d2, w_d1, w_d2;
  logic       h_v, w_v;
`ifdef PARITY_EN
  logic       h_pe, w_pe;
`endif

  always #5 clk = ~clk;

  regfile_2r1w #(.R0_HARDWIRED(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(h_d1), .rd_data2(h_d2), .rd_valid(h_v)
`ifdef PARITY_EN
    , .rd_perr(h_pe)
`endif
  );

  regfile_2r1w #(.R0_HARDWIRED(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(w_d1), .rd_data2(w_d2), .rd_valid(w_v)
`ifdef PARITY_EN
    , .rd_perr(w_pe)
`endif
  );

  typedef struct {
    logic [7:0] d1 [2];
    logic [7:0] d2 [2];
    logic       v;
    logic       pe;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mdl [2][8];
  logic [7:0] hold1 [2];
  logic [7:0] hold2 [2];
  int         bad = -1;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic we,
                      input logic [2:0] wa, input logic [7:0] wd,
                      input logic re, input logic [2:0] a1,
                      input logic [2:0] a2);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst_n = ~rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
    e.v  = rst ? 1'b0 : re;
    e.pe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bit hw;
      hw = (k == 0);
      if (rst) begin
        for (int i = 0; i < 8; i++) mdl[k][i] = (i == 0) ? 8'd13 : 8'd0;
        hold1[k] = 8'd0;
        hold2[k] = 8'd0;
      end else begin
        if (re) begin
          hold1[k] = (we && wa == a1 && !(hw && a1 == 0)) ? wd : mdl[k][a1];
          hold2[k] = (we && wa == a2 && !(hw && a2 == 0)) ? wd : mdl[k][a2];
        end
        if (we && !(hw && wa == 0)) mdl[k][wa] = wd;
      end
      e.d1[k] = hold1[k];
      e.d2[k] = hold2[k];
    end
    if (!rst && re && bad >= 0 &&
        ((a1 == bad && !(we && wa == a1)) ||
         (a2 == bad && !(we && wa == a2))))
      e.pe = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("valid_hw", {31'd0, h_v}, {31'd0, g.v});
    check("valid_wr", {31'd0, w_v}, {31'd0, g.v});
    check("rd1_hw", {24'd0, h_d1}, {24'd0, g.d1[0]});
    check("rd2_hw", {24'd0, h_d2}, {24'd0, g.d2[0]});
    check("rd1_wr", {24'd0, w_d1}, {24'd0, g.d1[1]});
    check("rd2_wr", {24'd0, w_d2}, {24'd0, g.d2[1]});
`ifdef PARITY_EN
    check("perr_hw", {31'd0, h_pe}, {31'd0, g.pe});
    check("perr_wr", {31'd0, w_pe}, 32'd0);
`endif
  endtask

  initial begin
    // 1: reset then read 0 and 5
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 5);
    // 2: write then read both ports
    step(0, 1, 3, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 3);
    // hold with rd_en low
    step(0, 0, 0, 0, 0, 1, 2);
    // 3: bypass over old value
    step(0, 1, 6, 8'h11, 0, 0, 0);
    step(0, 1, 6, 8'h3C, 1, 6, 3);
    step(0, 0, 0, 0, 1, 6, 6);
    // 4: entry 0 write with concurrent read, then re-read
    step(0, 1, 0, 8'hFF, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 6);
    // 5: fill, reset with wr_en high, read back
    for (int i = 0; i < 8; i++)
      step(0, 1, 3'(i), 8'(8'h10 + i), 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0);
    step(1, 1, 4, 8'h99, 1, 4, 4);
    for (int i = 0; i < 8; i += 2)
      step(0, 0, 0, 0, 1, 3'(i), 3'(i + 1));
    // random traffic
    for (int i = 0; i < 40; i++)
      step(0, 1'($urandom), 3'($urandom), 8'($urandom),
           1'($urandom), 3'($urandom), 3'($urandom));
`ifdef PARITY_EN
    // 6: parity injection on entry 2
    begin
      logic [7:0] pv;
      step(0, 1, 2, 8'h07, 0, 0, 0);
      pv = dut.par_q;
      pv[2] = ~pv[2];
      force dut.par_q = pv;
      bad = 2;
      step(0, 0, 0, 0, 1, 2, 1);
      step(0, 0, 0, 0, 1, 4, 4);
      step(0, 0, 0, 0, 0, 2, 2);
      release dut.par_q;
      step(0, 1, 2, 8'h07, 0, 0, 0);
      bad = -1;
      step(0, 0, 0, 0, 1, 2, 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
